// File: rtl/ccsds123_word_packer_pkg.sv
// Shared compression parameters for the word packer slice.
// BUS_WIDTH: output word width (multiple of 8).
// MAX_LEN:   longest codeword in bits (U_MAX + DYN_RANGE), 1..BUS_WIDTH.
// Also provides the accumulator/fill widths and the stream-byte swap helper.
package ccsds123_word_packer_pkg;

    localparam int unsigned BUS_WIDTH = 64;
    localparam int unsigned U_MAX     = 16;
    localparam int unsigned DYN_RANGE = 16;
    localparam int unsigned MAX_LEN   = U_MAX + DYN_RANGE;
    localparam int unsigned LEN_W     = $clog2(MAX_LEN + 1);
    localparam int unsigned ACC_W     = BUS_WIDTH + MAX_LEN;
    localparam int unsigned FILL_W    = $clog2(ACC_W + 1);

    // MSB-first word -> stream byte k placed at bits [8k+:8]
    function automatic logic [BUS_WIDTH-1:0] byte_swap(input logic [BUS_WIDTH-1:0] w);
        logic [BUS_WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < int'(BUS_WIDTH / 8); k++) begin
            r[8*k +: 8] = w[int'(BUS_WIDTH) - 1 - 8*k -: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/ccsds123_word_packer_if.sv
// Codeword input stream plus packed-word output stream of the word packer.
// master: codeword producer / word consumer side.
// slave:  the packer itself.
interface ccsds123_word_packer_if;
    import ccsds123_word_packer_pkg::*;

    logic [MAX_LEN-1:0]   in_data;
    logic [LEN_W-1:0]     in_len;
    logic                 in_last;
    logic                 in_valid;
    logic                 in_ready;
    logic [BUS_WIDTH-1:0] out_tdata;
    logic                 out_tvalid;
    logic                 out_tready;
    logic                 out_tlast;

    modport master (
        output in_data, in_len, in_last, in_valid, out_tready,
        input  in_ready, out_tdata, out_tvalid, out_tlast
    );

    modport slave (
        input  in_data, in_len, in_last, in_valid, out_tready,
        output in_ready, out_tdata, out_tvalid, out_tlast
    );

endinterface

// File: rtl/ccsds123_word_packer_bit_append.sv
// Combinational accumulator update: optional left shift by one output word,
// then OR-in of the masked codeword directly after the remaining fill.
// Ports: acc/fill (current), emit (word leaves this cycle), accept (codeword
// taken this cycle), data/len (codeword), acc_next/fill_next (results).
module ccsds123_word_packer_bit_append
    import ccsds123_word_packer_pkg::*;
(
    input  logic [ACC_W-1:0]   acc,
    input  logic [FILL_W-1:0]  fill,
    input  logic               emit,
    input  logic               accept,
    input  logic [MAX_LEN-1:0] data,
    input  logic [LEN_W-1:0]   len,
    output logic [ACC_W-1:0]   acc_next,
    output logic [FILL_W-1:0]  fill_next
);

    logic [ACC_W-1:0]   shifted;
    logic [FILL_W-1:0]  fill_base;
    logic [MAX_LEN-1:0] masked;
    logic [FILL_W-1:0]  sh;

    always_comb begin
        shifted   = acc;
        fill_base = fill;
        masked    = '0;
        sh        = '0;
        acc_next  = acc;
        fill_next = fill;

        // a flushed partial word leaves fill at zero, never negative
        if (emit) begin
            shifted   = acc << BUS_WIDTH;
            fill_base = (fill >= FILL_W'(BUS_WIDTH)) ? fill - FILL_W'(BUS_WIDTH) : '0;
        end

        // bits above len are don't-care on the input and must not leak in
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            masked[i] = data[i] & (LEN_W'(i) < len);
        end

        // codeword MSB lands at stream position fill_base
        sh = FILL_W'(ACC_W) - fill_base - FILL_W'(len);

        acc_next  = shifted;
        fill_next = fill_base;
        if (accept) begin
            acc_next  = shifted | (ACC_W'(masked) << sh);
            fill_next = fill_base + FILL_W'(len);
        end
    end

endmodule

// File: rtl/ccsds123_word_packer.sv
// Packs variable-length codewords MSB-first into BUS_WIDTH-bit words and
// zero-pads/flushes the tail of each image with tlast on the final word.
// Ports: clk, aresetn (async active-low), bus (slave modport: in_* codeword
// stream, out_t* AXI-style word stream).
module ccsds123_word_packer
    import ccsds123_word_packer_pkg::*;
(
    input  logic                   clk,
    input  logic                   aresetn,
    ccsds123_word_packer_if.slave  bus
);

    typedef enum logic {
        PACK  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t               state;
    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     acc_next;
    logic [FILL_W-1:0]    fill;
    logic [FILL_W-1:0]    fill_next;
    logic                 pending_last;
    logic [BUS_WIDTH-1:0] tdata_q;
    logic                 tvalid_q;
    logic                 tlast_q;

    logic                 out_free_c;
    logic                 ready_c;
    logic                 accept_c;
    logic                 emit_c;
    logic                 tlast_next_c;

    assign out_free_c = !tvalid_q || bus.out_tready;
    assign ready_c    = aresetn && (state == PACK) &&
                        ((fill < FILL_W'(BUS_WIDTH)) || out_free_c);
    assign accept_c   = bus.in_valid && ready_c;

    // Emit a full word, or while flushing any remainder; with nothing left
    // and no tlast word outstanding, flushing emits the all-zero tlast word.
    always_comb begin
        emit_c = 1'b0;
        if (out_free_c) begin
            if (fill >= FILL_W'(BUS_WIDTH)) begin
                emit_c = 1'b1;
            end else if (state == FLUSH && (fill != '0 || !(tvalid_q && tlast_q))) begin
                emit_c = 1'b1;
            end
        end
    end

    ccsds123_word_packer_bit_append u_bit_append (
        .acc       (acc),
        .fill      (fill),
        .emit      (emit_c),
        .accept    (accept_c),
        .data      (bus.in_data),
        .len       (bus.in_len),
        .acc_next  (acc_next),
        .fill_next (fill_next)
    );

    // an image ending exactly on a boundary tags that full word as last
    assign tlast_next_c = (pending_last || (accept_c && bus.in_last)) && (fill_next == '0);

    // State, accumulator and registered output word
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= PACK;
            acc          <= '0;
            fill         <= '0;
            pending_last <= 1'b0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
        end else begin
            acc  <= acc_next;
            fill <= fill_next;

            if (emit_c) begin
                tdata_q  <= byte_swap(acc[ACC_W-1 -: BUS_WIDTH]);
                tvalid_q <= 1'b1;
                tlast_q  <= tlast_next_c;
            end else if (bus.out_tready) begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
            end

            case (state)
                PACK: begin
                    if (accept_c && bus.in_last) begin
                        state        <= FLUSH;
                        pending_last <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (tvalid_q && bus.out_tready && tlast_q) begin
                        state        <= PACK;
                        pending_last <= 1'b0;
                    end
                end
                default: state <= PACK;
            endcase
        end
    end

    assign bus.in_ready   = ready_c;
    assign bus.out_tdata  = tdata_q;
    assign bus.out_tvalid = tvalid_q;
    assign bus.out_tlast  = tlast_q;

endmodule
